ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
- Instruction-fetch front end of the multi-cycle MIPS datapath.
- Holds the architectural PC and feeds it to the next-PC calculator. Loads the calculated next PC back on command.
- Acts as the reading master on the instruction-memory request/acknowledge interface and captures the fetched word into the instruction register.
- The control FSM drives fetch_go and pc_wr.

Parameters:
- RESET_PC, 30'h0C00, word address loaded into pc on reset (byte address 0x0000_3000).
- TIMEOUT_CYC, 16, maximum WAIT cycles before a fetch is abandoned (used only with IFU_BUS_TIMEOUT_EN).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- npc  input  30  next PC [31:2] from the next-PC block
- pc_wr  input  1  load npc into pc at this edge
- fetch_go  input  1  start fetch of current pc
- pc  output  30  architectural PC [31:2]; feeds the next-PC block
- instr  output  32  instruction register
- instr_valid  output  1  instr holds a completed fetch
- busy  output  1  fetch in flight (state WAIT)
- imem_req  output  1  read request, registered
- imem_addr  output  30  word address, registered, stable while imem_req=1
- imem_ack  input  1  memory accepted request; imem_rdata valid this cycle
- imem_rdata  input  32  read data
- fetch_err  output  1  abandoned fetch flag; tied 0 without IFU_BUS_TIMEOUT_EN

Behaviour:
- Reset values:
  - pc = RESET_PC, imem_addr = RESET_PC
  - instr = 0, instr_valid = 0, imem_req = 0, busy = 0, fetch_err = 0
  - state = IDLE
  - rst overrides all other inputs, including mid-fetch: the request drops immediately and a late ack is ignored.
- pc register:
  - pc <= npc on any edge with pc_wr=1, in any state.
  - No other pc update path.
- States: IDLE, WAIT.
- IDLE, fetch_go=1:
  - imem_addr <= pc, using the pre-edge value, so a simultaneous pc_wr fetches the old PC (the standard IR<-M[PC], PC<-PC+4 step).
  - imem_req <= 1, instr_valid <= 0, fetch_err <= 0, state <= WAIT.
- IDLE, fetch_go=0: hold all outputs.
- WAIT:
  - imem_req held 1 and imem_addr held constant until imem_ack is sampled 1.
  - On imem_ack=1: instr <= imem_rdata, instr_valid <= 1, imem_req <= 0, state <= IDLE.
  - fetch_go in WAIT is ignored (not queued).
  - pc_wr in WAIT updates pc only; the in-flight imem_addr is unaffected.
- busy = (state == WAIT), combinational from the state register.
- Latency:
  - fetch_go sampled at edge N → imem_req high after edge N.
  - Earliest ack sample is at edge N+1 → instr_valid high after N+1 (2-cycle minimum).
  - Each extra cycle of ack delay adds one cycle.
- instr and instr_valid hold indefinitely in IDLE. A new accepted fetch_go clears instr_valid; instr keeps its old value until the next capture.
- imem_ack while IDLE is ignored.
- Back-to-back: fetch_go may be asserted on the first IDLE cycle after capture. No dead cycle beyond the state return.

Optional Feature:
- Macro: IFU_BUS_TIMEOUT_EN.
- With the macro defined:
  - A $clog2(TIMEOUT_CYC)+1-bit counter clears on WAIT entry and increments each WAIT cycle without ack.
  - If ack is still absent on the TIMEOUT_CYC-th WAIT edge: imem_req <= 0, instr <= 32'h0000_0000 (NOP), instr_valid <= 1, fetch_err <= 1, state <= IDLE.
  - An ack arriving on that same edge wins: normal capture, no error.
  - fetch_err is sticky until the next accepted fetch_go or rst.
- Without the macro: WAIT persists until ack; no counter logic; fetch_err is constant 0.

Decomposition:
- DEFINE.v (shared include) gains:
  - IFU_IDLE / IFU_WAIT state encodings (1 bit)
  - the RESET_PC default value
  - the NOP encoding constant
- Natural sub-module: pc_reg. A 30-bit register with synchronous reset-to-RESET_PC and a load enable (pc_wr). It is instantiated once; the FSM, the instruction register and the timeout counter stay in ifetch_unit.

Test Plan:
- Reset then idle 5 cycles → pc=30'h0C00, imem_req=0, instr_valid=0, instr=0.
- fetch_go with pc_wr=1 and npc=30'h0C01 in the same cycle, ack on the first WAIT cycle with rdata=32'h2408_0005:
  - imem_addr=30'h0C00
  - instr=32'h2408_0005 and instr_valid=1 two cycles after fetch_go
  - pc=30'h0C01
- Ack delayed 4 cycles:
  - imem_req stays 1 and imem_addr stays constant for all 4 cycles.
  - fetch_go pulses during WAIT are ignored.
  - pc_wr with npc=30'h0D00 in WAIT changes pc but not imem_addr.
- Three back-to-back fetches with immediate ack, rdata 32'h1,2,3 → instr sequence 1,2,3. instr_valid drops for exactly the one cycle after each new fetch_go.
- rst asserted in WAIT, ack arriving the next cycle → all outputs at reset values; ack ignored; pc=30'h0C00.
- IFU_BUS_TIMEOUT_EN defined, TIMEOUT_CYC=16, no ack:
  - After 16 WAIT edges: instr=0, instr_valid=1, fetch_err=1, imem_req=0.
  - A late ack in IDLE is ignored.
  - The next fetch_go clears fetch_err.

Source files
------------

// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM encodings,
// reset PC and the NOP word returned by an abandoned fetch.
package ifetch_unit_pkg;

  typedef enum logic {
    IFU_IDLE = 1'b0,
    IFU_WAIT = 1'b1
  } ifu_state_t;

  localparam logic [29:0] IFU_RESET_PC = 30'h0C00;
  localparam logic [31:0] IFU_NOP      = 32'h0000_0000;

endpackage

// File: rtl/ifetch_unit_pc_reg.sv
// Architectural PC register: synchronous reset to RESET_PC, loads npc when
// pc_wr is high. This is the only path that changes the PC.
module ifetch_unit_pc_reg
  import ifetch_unit_pkg::*;
#(
  parameter logic [29:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_wr,
  input  logic [29:0] npc,
  output logic [29:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (pc_wr) begin
      pc <= npc;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: PC, instruction-memory read master and
// instruction register. Optional bus timeout enabled by IFU_BUS_TIMEOUT_EN.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [29:0] RESET_PC = IFU_RESET_PC
`ifdef IFU_BUS_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 16
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] npc,
  input  logic        pc_wr,
  input  logic        fetch_go,
  output logic [29:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        busy,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        fetch_err
);

  // Handshake: imem_req/imem_addr are registered and held stable until
  // imem_ack is sampled high on a rising edge; that edge also transfers imem_rdata.

  ifu_state_t state, state_next;
  logic       start;
  logic       capture;

  ifetch_unit_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk   (clk),
    .rst   (rst),
    .pc_wr (pc_wr),
    .npc   (npc),
    .pc    (pc)
  );

`ifdef IFU_BUS_TIMEOUT_EN
  localparam int             CNT_W    = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo;
`endif

  assign busy = (state == IFU_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IFU_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    capture    = 1'b0;
`ifdef IFU_BUS_TIMEOUT_EN
    tmo        = 1'b0;
`endif
    case (state)
      IFU_IDLE: begin
        if (fetch_go) begin
          start      = 1'b1;
          state_next = IFU_WAIT;
        end
      end
      IFU_WAIT: begin
        // An ack on the timeout edge still wins over the abandon path.
        if (imem_ack) begin
          capture    = 1'b1;
          state_next = IFU_IDLE;
        end
`ifdef IFU_BUS_TIMEOUT_EN
        else if (tmo_cnt == TMO_LAST) begin
          tmo        = 1'b1;
          state_next = IFU_IDLE;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      // imem_addr takes the pre-edge pc, so a simultaneous pc_wr fetches the old PC.
      if (start) begin
        imem_addr   <= pc;
        imem_req    <= 1'b1;
        instr_valid <= 1'b0;
      end
      if (capture) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
        imem_req    <= 1'b0;
      end
`ifdef IFU_BUS_TIMEOUT_EN
      if (tmo) begin
        instr       <= IFU_NOP;
        instr_valid <= 1'b1;
        imem_req    <= 1'b0;
      end
`endif
    end
  end

`ifdef IFU_BUS_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt   <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (start) begin
        tmo_cnt   <= '0;
        fetch_err <= 1'b0;
      end else if (state == IFU_WAIT && !imem_ack) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (tmo) begin
        fetch_err <= 1'b1;
      end
    end
  end
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit; inputs change and outputs are sampled
// on the falling edge. Timeout scenario is built only with IFU_BUS_TIMEOUT_EN.
module tb_ifetch_unit;

  logic        clk;
  logic        rst;
  logic [29:0] npc;
  logic        pc_wr;
  logic        fetch_go;
  logic [29:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        busy;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        fetch_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  logic        prev_valid = 1'b0;
  logic [29:0] exp_pc;

  ifetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .npc         (npc),
    .pc_wr       (pc_wr),
    .fetch_go    (fetch_go),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .busy        (busy),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .fetch_err   (fetch_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst        = 1'b1;
    npc        = '0;
    pc_wr      = 1'b0;
    fetch_go   = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
  end

  // scoreboard: every rising instr_valid consumes one expected word
  always @(negedge clk) begin
    if (!rst && instr_valid && !prev_valid) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: instr=%h with empty expected queue", instr);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (instr !== e) begin
          n_fail++;
          $display("FAIL sb_instr: got %h expected %h", instr, e);
        end
      end
    end
    prev_valid = instr_valid;
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++; if (pc !== 30'h0C00) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, 30'h0C00); end
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    n_tests++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", instr); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (imem_addr !== 30'h0C00) begin n_fail++; $display("FAIL reset_addr: got %h expected %h", imem_addr, 30'h0C00); end
    n_tests++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", fetch_err); end
    exp_pc = 30'h0C00;
  endtask

  task automatic test_fetch_pc_wr();
    fetch_go = 1'b1; pc_wr = 1'b1; npc = 30'h0C01;
    exp_q.push_back(32'h2408_0005);
    @(negedge clk);
    fetch_go = 1'b0; pc_wr = 1'b0;
    exp_pc = 30'h0C01;
    n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL fetch_req: got %b expected 1", imem_req); end
    n_tests++; if (imem_addr !== 30'h0C00) begin n_fail++; $display("FAIL fetch_addr: got %h expected %h", imem_addr, 30'h0C00); end
    n_tests++; if (pc !== 30'h0C01) begin n_fail++; $display("FAIL fetch_pc: got %h expected %h", pc, 30'h0C01); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fetch_busy: got %b expected 1", busy); end
    imem_ack = 1'b1; imem_rdata = 32'h2408_0005;
    @(negedge clk);
    imem_ack = 1'b0;
    n_tests++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_valid: got %b expected 1", instr_valid); end
    n_tests++; if (instr !== 32'h2408_0005) begin n_fail++; $display("FAIL fetch_instr: got %h expected %h", instr, 32'h2408_0005); end
    n_tests++; if (imem_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL fetch_done: req=%b busy=%b expected 0 0", imem_req, busy); end
  endtask

  task automatic test_ack_delay();
    logic [29:0] addr0;
    addr0 = exp_pc;
    fetch_go = 1'b1;
    exp_q.push_back(32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      fetch_go = (i == 0);
      pc_wr    = (i == 1);
      npc      = 30'h0D00;
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== addr0) begin
        n_fail++;
        $display("FAIL delay_hold[%0d]: req=%b addr=%h expected 1 %h", i, imem_req, imem_addr, addr0);
      end
    end
    @(negedge clk);
    fetch_go = 1'b0; pc_wr = 1'b0;
    exp_pc = 30'h0D00;
    n_tests++; if (pc !== 30'h0D00) begin n_fail++; $display("FAIL delay_pc: got %h expected %h", pc, 30'h0D00); end
    n_tests++; if (imem_addr !== addr0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL delay_addr: addr=%h valid=%b expected %h 0", imem_addr, instr_valid, addr0); end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    n_tests++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL delay_valid: got %b expected 1", instr_valid); end
    @(negedge clk);
    n_tests++; if (busy !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL delay_go_ignored: busy=%b req=%b expected 0 0", busy, imem_req); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      logic [29:0] addr_e;
      addr_e   = exp_pc;
      fetch_go = 1'b1; pc_wr = 1'b1; npc = exp_pc + 30'd1;
      exp_q.push_back(32'(i + 1));
      @(negedge clk);
      fetch_go = 1'b0; pc_wr = 1'b0;
      exp_pc = exp_pc + 30'd1;
      n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drop[%0d]: got %b expected 0", i, instr_valid); end
      n_tests++; if (imem_addr !== addr_e) begin n_fail++; $display("FAIL b2b_addr[%0d]: got %h expected %h", i, imem_addr, addr_e); end
      imem_ack = 1'b1; imem_rdata = 32'(i + 1);
      @(negedge clk);
      imem_ack = 1'b0;
      n_tests++; if (instr_valid !== 1'b1 || instr !== 32'(i + 1)) begin n_fail++; $display("FAIL b2b_cap[%0d]: valid=%b instr=%h expected 1 %h", i, instr_valid, instr, 32'(i + 1)); end
    end
  endtask

  task automatic test_idle_ack();
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
    repeat (2) @(negedge clk);
    imem_ack = 1'b0;
    n_tests++; if (instr !== 32'h3 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_ack: instr=%h busy=%b expected 00000003 0", instr, busy); end
    n_tests++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL idle_err: got %b expected 0", fetch_err); end
  endtask

  task automatic test_reset_mid_fetch();
    fetch_go = 1'b1;
    @(negedge clk);
    fetch_go = 1'b0;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    imem_ack = 1'b0;
    exp_pc = 30'h0C00;
    n_tests++; if (pc !== 30'h0C00 || imem_addr !== 30'h0C00) begin n_fail++; $display("FAIL rstmid_pc: pc=%h addr=%h expected 0c00 0c00", pc, imem_addr); end
    n_tests++; if (imem_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_req: req=%b busy=%b expected 0 0", imem_req, busy); end
    n_tests++; if (instr !== 32'h0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_instr: instr=%h valid=%b expected 0 0", instr, instr_valid); end
  endtask

`ifdef IFU_BUS_TIMEOUT_EN
  task automatic test_timeout();
    fetch_go = 1'b1;
    exp_q.push_back(32'h0);
    @(negedge clk);
    fetch_go = 1'b0;
    repeat (15) @(negedge clk);
    n_tests++; if (busy !== 1'b1 || fetch_err !== 1'b0) begin n_fail++; $display("FAIL tmo_early: busy=%b err=%b expected 1 0", busy, fetch_err); end
    @(negedge clk);
    n_tests++; if (instr_valid !== 1'b1 || fetch_err !== 1'b1) begin n_fail++; $display("FAIL tmo_flag: valid=%b err=%b expected 1 1", instr_valid, fetch_err); end
    n_tests++; if (imem_req !== 1'b0 || instr !== 32'h0) begin n_fail++; $display("FAIL tmo_nop: req=%b instr=%h expected 0 0", imem_req, instr); end
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    @(negedge clk);
    imem_ack = 1'b0;
    n_tests++; if (fetch_err !== 1'b1 || instr !== 32'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL tmo_late_ack: err=%b instr=%h busy=%b expected 1 0 0", fetch_err, instr, busy); end
    fetch_go = 1'b1;
    exp_q.push_back(32'h5555_AAAA);
    @(negedge clk);
    fetch_go = 1'b0;
    n_tests++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: got %b expected 0", fetch_err); end
    imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    imem_ack = 1'b0;
  endtask
`endif

  task automatic test_random_delays();
    for (int i = 0; i < 6; i++) begin
      int unsigned dly;
      int unsigned waited;
      logic [31:0] d;
      dly = $urandom_range(0, 5);
      d   = $urandom;
      fetch_go = 1'b1;
      exp_q.push_back(d);
      @(negedge clk);
      fetch_go = 1'b0;
      repeat (dly) @(negedge clk);
      imem_ack = 1'b1; imem_rdata = d;
      @(negedge clk);
      imem_ack = 1'b0;
      waited = 0;
      while (!instr_valid && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 20) begin
        n_tests++; n_fail++;
        $display("FAIL rand_timeout[%0d]: instr_valid never rose", i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch_pc_wr();
    test_ack_delay();
    test_back_to_back();
    test_idle_ack();
    test_reset_mid_fetch();
    test_random_delays();
`ifdef IFU_BUS_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d expected words never produced", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
